// File: rtl/si_tag_pkg.sv
// si_tag_pkg
// Constants shared by the tag encoder and its helpers.
// Defines the raw 32-bit tag word layout:
//   {type[31:30], channel[29:24], subtime[23:12], counter[11:0]}
// It also defines the widths of the decoded tag fields.
package si_tag_pkg;

    localparam logic [1:0] SI_TAG_EVENT_TYPE      = 2'b01;
    localparam int         SI_SUBTICKS_PER_PERIOD = 4000;

    // Raw tag word field positions
    localparam int TAG_TYPE_MSB = 31;
    localparam int TAG_TYPE_LSB = 30;
    localparam int TAG_CHAN_MSB = 29;
    localparam int TAG_CHAN_LSB = 24;
    localparam int TAG_SUB_MSB  = 23;
    localparam int TAG_SUB_LSB  = 12;
    localparam int TAG_CNT_MSB  = 11;
    localparam int TAG_CNT_LSB  = 0;

    // Decoded tag field widths
    localparam int TAG_W       = 32;
    localparam int COARSE_W    = 44;
    localparam int COARSE_LO_W = 12;
    localparam int SUBTIME_W   = 12;
    localparam int CHANNEL_W   = 6;
    localparam int WRAP_W      = COARSE_W - COARSE_LO_W;

endpackage

// File: rtl/si_tag_encoder_if.sv
// si_tag_encoder_if
// Bundles the decoded-tag input stream and the packed-beat output stream.
// Ports inside the bundle:
//   s_axis_tvalid/tready/coarse/subtime/channel/tlast : decoded tag input
//   m_axis_tvalid/tready/tdata/tkeep/tuser/tlast      : packed AXI-Stream beat
// Modports:
//   slave  : the encoder (consumes tags, produces beats)
//   master : the tag source / beat sink around the encoder
interface si_tag_encoder_if
    import si_tag_pkg::*;
#(
    parameter int DATA_WIDTH_OUT = 128,
    parameter int KEEP_WIDTH_OUT = (DATA_WIDTH_OUT + 7) / 8
);

    logic                        s_axis_tvalid;
    logic                        s_axis_tready;
    logic [COARSE_W-1:0]         s_axis_coarse;
    logic [SUBTIME_W-1:0]        s_axis_subtime;
    logic signed [CHANNEL_W-1:0] s_axis_channel;
    logic                        s_axis_tlast;

    logic                        m_axis_tvalid;
    logic                        m_axis_tready;
    logic [DATA_WIDTH_OUT-1:0]   m_axis_tdata;
    logic [KEEP_WIDTH_OUT-1:0]   m_axis_tkeep;
    logic [WRAP_W-1:0]           m_axis_tuser;
    logic                        m_axis_tlast;

    modport slave (
        input  s_axis_tvalid, s_axis_coarse, s_axis_subtime, s_axis_channel, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tvalid, s_axis_coarse, s_axis_subtime, s_axis_channel, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast,
        output m_axis_tready
    );

endinterface

// File: rtl/si_tag_word_pack.sv
// si_tag_word_pack
// Combinational tag word builder.
// It maps the signed channel to the raw channel number:
//   +n -> n-1
//   -n -> CHANNEL_COUNT-1+n
// It range-checks the channel and the subtime, then assembles the raw 32-bit word.
// Ports:
//   coarse_lo : coarse[11:0], the in-wrap counter field
//   subtime   : sub-period time, valid 0..3999
//   channel   : signed channel, valid +-1..+-CHANNEL_COUNT
//   word      : assembled raw tag word
//   drop      : tag must not be packed (bad channel or subtime)
module si_tag_word_pack
    import si_tag_pkg::*;
#(
    parameter int CHANNEL_COUNT = 20
) (
    input  logic [COARSE_LO_W-1:0]      coarse_lo,
    input  logic [SUBTIME_W-1:0]        subtime,
    input  logic signed [CHANNEL_W-1:0] channel,
    output logic [TAG_W-1:0]            word,
    output logic                        drop
);

    localparam logic signed [CHANNEL_W:0] CH_LIMIT  = (CHANNEL_W + 1)'(CHANNEL_COUNT);
    localparam logic [CHANNEL_W-1:0]      CH_MINUS1 = CHANNEL_W'(CHANNEL_COUNT - 1);
    localparam logic [SUBTIME_W-1:0]      SUB_LIMIT = SUBTIME_W'(SI_SUBTICKS_PER_PERIOD);

    logic signed [CHANNEL_W:0] ch_ext;
    logic signed [CHANNEL_W:0] ch_mag;
    logic [CHANNEL_W-1:0]      ch_num;

    always_comb begin
        // One extra bit so that |-32| does not overflow.
        ch_ext = {channel[CHANNEL_W-1], channel};
        ch_mag = channel[CHANNEL_W-1] ? -ch_ext : ch_ext;

        // The result is only used for valid channels.
        // In that range, modular 6-bit arithmetic gives the exact channel number.
        if (channel[CHANNEL_W-1]) begin
            ch_num = CH_MINUS1 - $unsigned(channel);
        end else begin
            ch_num = $unsigned(channel) - CHANNEL_W'(1);
        end

        drop = (channel == '0) || (ch_mag > CH_LIMIT) || (subtime >= SUB_LIMIT);

        word = '0;
        word[TAG_TYPE_MSB:TAG_TYPE_LSB] = SI_TAG_EVENT_TYPE;
        word[TAG_CHAN_MSB:TAG_CHAN_LSB] = ch_num;
        word[TAG_SUB_MSB:TAG_SUB_LSB]   = subtime;
        word[TAG_CNT_MSB:TAG_CNT_LSB]   = coarse_lo;
    end

endmodule

// File: rtl/si_tag_encoder.sv
// si_tag_encoder
// Packs decoded time tags into raw 32-bit tag words.
// Up to NUMBER_OF_WORDS tags go into one AXI-Stream beat.
// All words of a beat share the rollover count coarse[43:12].
// That count is carried in tuser.
// A beat is closed when any of these happens:
//   - the last slot is filled
//   - an input tlast arrives
//   - the rollover count changes
//   - the accumulator has been idle for FLUSH_TIMEOUT cycles (0 disables this)
// Ports:
//   clk, rst      : single clock, synchronous active-high reset
//   bus (slave)   : s_axis_* tag input, m_axis_* beat output
//   dropped_count : number of dropped tags
// Optional feature:
//   SI_TAG_ENCODER_STATS_EN defined  : dropped_count is a saturating counter.
//   SI_TAG_ENCODER_STATS_EN undefined: dropped_count is tied to zero.
module si_tag_encoder
    import si_tag_pkg::*;
#(
    parameter int CHANNEL_COUNT   = 20,
    parameter int DATA_WIDTH_OUT  = 128,
    parameter int KEEP_WIDTH_OUT  = (DATA_WIDTH_OUT + 7) / 8,
    parameter int NUMBER_OF_WORDS = (DATA_WIDTH_OUT + 31) / 32,
    parameter int FLUSH_TIMEOUT   = 64
) (
    input  logic            clk,
    input  logic            rst,
    si_tag_encoder_if.slave bus,
    output logic [31:0]     dropped_count
);

    localparam int NOW    = NUMBER_OF_WORDS;
    localparam int CNT_W  = $clog2(NOW);
    localparam int ACC_W  = NOW * TAG_W;
    localparam int KACC_W = NOW * 4;
    localparam int IDLE_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;

    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'((FLUSH_TIMEOUT > 1) ? FLUSH_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0]  SLOT_LAST  = CNT_W'(NOW - 1);
    localparam bit                TIMEOUT_EN = (FLUSH_TIMEOUT > 0);

    logic [TAG_W-1:0]  tag_word;
    logic              tag_drop;
    logic [WRAP_W-1:0] tag_wrap;
    logic              out_free;
    logic              tag_ready;
    logic              accept;
    logic              acc_busy;

    // Accumulator
    logic [CNT_W-1:0]            acc_cnt, acc_cnt_nxt;
    logic [WRAP_W-1:0]           acc_wrap, acc_wrap_nxt;
    logic [NOW-1:0][TAG_W-1:0]   acc_data, acc_data_nxt;
    logic [NOW-1:0][3:0]         acc_keep, acc_keep_nxt;
    logic                        acc_last_pend, acc_last_pend_nxt;
    logic [IDLE_W-1:0]           idle_cnt, idle_cnt_nxt;

    // Accumulator with the incoming tag placed in slot acc_cnt
    logic [NOW-1:0][TAG_W-1:0]   ins_data;
    logic [NOW-1:0][3:0]         ins_keep;

    logic flush_acc;
    logic flush_last;

    // Output register
    logic              beat_vld_p1, beat_vld_nxt;
    logic [ACC_W-1:0]  beat_data_p1, beat_data_nxt;
    logic [KACC_W-1:0] beat_keep_p1, beat_keep_nxt;
    logic [WRAP_W-1:0] beat_user_p1, beat_user_nxt;
    logic              beat_last_p1, beat_last_nxt;

    si_tag_word_pack #(
        .CHANNEL_COUNT (CHANNEL_COUNT)
    ) u_pack (
        .coarse_lo (bus.s_axis_coarse[COARSE_LO_W-1:0]),
        .subtime   (bus.s_axis_subtime),
        .channel   (bus.s_axis_channel),
        .word      (tag_word),
        .drop      (tag_drop)
    );

    assign tag_wrap  = bus.s_axis_coarse[COARSE_W-1:COARSE_LO_W];
    assign out_free  = !beat_vld_p1 || bus.m_axis_tready;
    // A pending tlast holds off new tags until its beat has been emitted.
    assign tag_ready = out_free && !acc_last_pend;
    assign accept    = bus.s_axis_tvalid && tag_ready;
    assign acc_busy  = (acc_cnt != '0);

    always_comb begin
        ins_data = acc_data;
        ins_keep = acc_keep;
        for (int i = 0; i < NOW; i++) begin
            if (CNT_W'(i) == acc_cnt) begin
                ins_data[i] = tag_word;
                ins_keep[i] = 4'hF;
            end
        end
    end

    always_comb begin
        acc_cnt_nxt       = acc_cnt;
        acc_wrap_nxt      = acc_wrap;
        acc_data_nxt      = acc_data;
        acc_keep_nxt      = acc_keep;
        acc_last_pend_nxt = acc_last_pend;
        idle_cnt_nxt      = idle_cnt;
        beat_vld_nxt      = beat_vld_p1 && !bus.m_axis_tready;
        beat_data_nxt     = beat_data_p1;
        beat_keep_nxt     = beat_keep_p1;
        beat_user_nxt     = beat_user_p1;
        beat_last_nxt     = beat_last_p1;
        flush_acc         = 1'b0;
        flush_last        = 1'b0;

        if (accept || !acc_busy) begin
            idle_cnt_nxt = '0;
        end else if (idle_cnt != IDLE_LAST) begin
            idle_cnt_nxt = idle_cnt + IDLE_W'(1);
        end

        if (accept && !tag_drop) begin
            if (acc_busy && (tag_wrap != acc_wrap)) begin
                // Rollover changed: the old words go out and the tag starts a new beat.
                beat_vld_nxt      = 1'b1;
                beat_data_nxt     = acc_data;
                beat_keep_nxt     = acc_keep;
                beat_user_nxt     = acc_wrap;
                beat_last_nxt     = 1'b0;
                acc_data_nxt      = '0;
                acc_data_nxt[0]   = tag_word;
                acc_keep_nxt      = '0;
                acc_keep_nxt[0]   = 4'hF;
                acc_cnt_nxt       = CNT_W'(1);
                acc_wrap_nxt      = tag_wrap;
                acc_last_pend_nxt = bus.s_axis_tlast;
            end else if ((acc_cnt == SLOT_LAST) || bus.s_axis_tlast) begin
                beat_vld_nxt  = 1'b1;
                beat_data_nxt = ins_data;
                beat_keep_nxt = ins_keep;
                beat_user_nxt = tag_wrap;
                beat_last_nxt = bus.s_axis_tlast;
                acc_cnt_nxt   = '0;
                acc_data_nxt  = '0;
                acc_keep_nxt  = '0;
            end else begin
                acc_data_nxt = ins_data;
                acc_keep_nxt = ins_keep;
                acc_cnt_nxt  = acc_cnt + CNT_W'(1);
                acc_wrap_nxt = tag_wrap;
            end
        end else if (accept) begin
            // A dropped tag still closes the packet if words are waiting.
            if (bus.s_axis_tlast && acc_busy) begin
                flush_acc  = 1'b1;
                flush_last = 1'b1;
            end
        end else if (acc_last_pend && out_free) begin
            flush_acc         = 1'b1;
            flush_last        = 1'b1;
            acc_last_pend_nxt = 1'b0;
        end else if (TIMEOUT_EN && acc_busy && out_free && (idle_cnt == IDLE_LAST)) begin
            flush_acc  = 1'b1;
            flush_last = 1'b0;
        end

        if (flush_acc) begin
            beat_vld_nxt  = 1'b1;
            beat_data_nxt = acc_data;
            beat_keep_nxt = acc_keep;
            beat_user_nxt = acc_wrap;
            beat_last_nxt = flush_last;
            acc_cnt_nxt   = '0;
            acc_data_nxt  = '0;
            acc_keep_nxt  = '0;
            idle_cnt_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt       <= '0;
            acc_wrap      <= '0;
            acc_data      <= '0;
            acc_keep      <= '0;
            acc_last_pend <= 1'b0;
            idle_cnt      <= '0;
            beat_vld_p1   <= 1'b0;
            beat_data_p1  <= '0;
            beat_keep_p1  <= '0;
            beat_user_p1  <= '0;
            beat_last_p1  <= 1'b0;
        end else begin
            acc_cnt       <= acc_cnt_nxt;
            acc_wrap      <= acc_wrap_nxt;
            acc_data      <= acc_data_nxt;
            acc_keep      <= acc_keep_nxt;
            acc_last_pend <= acc_last_pend_nxt;
            idle_cnt      <= idle_cnt_nxt;
            beat_vld_p1   <= beat_vld_nxt;
            beat_data_p1  <= beat_data_nxt;
            beat_keep_p1  <= beat_keep_nxt;
            beat_user_p1  <= beat_user_nxt;
            beat_last_p1  <= beat_last_nxt;
        end
    end

    assign bus.s_axis_tready = tag_ready;
    assign bus.m_axis_tvalid = beat_vld_p1;
    assign bus.m_axis_tdata  = beat_data_p1[DATA_WIDTH_OUT-1:0];
    assign bus.m_axis_tkeep  = beat_keep_p1[KEEP_WIDTH_OUT-1:0];
    assign bus.m_axis_tuser  = beat_user_p1;
    assign bus.m_axis_tlast  = beat_last_p1;

`ifdef SI_TAG_ENCODER_STATS_EN
    logic        drop_inc;
    logic [31:0] drop_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign drop_inc = accept && tag_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_inc) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

    assign dropped_count = drop_cnt;
`else
    assign dropped_count = '0;
`endif

endmodule
